// File: rtl/fpga_cfg_pkg.sv
// Shared configuration-chain constants and helpers for the eFPGA CCFF core.
package fpga_cfg_pkg;

    // Full bitstream length and scan chain length of the fabric.
    localparam int CCFF_LEN_DEF = 29696;
    localparam int SC_LEN_DEF   = 8;

    // Counter must be able to represent CCFF_LEN+1 (the saturation value).
    function automatic int cnt_width(input int len);
        return $clog2(len + 2);
    endfunction

    localparam int CNT_W_DEF = $clog2(CCFF_LEN_DEF + 2);

endpackage

// File: rtl/fpga_ccff_chain_if.sv
// Bundle of the configuration and scan chain signals between the pads/loader and the core.
interface fpga_ccff_chain_if
    import fpga_cfg_pkg::*;
#(
    parameter int CCFF_LEN = CCFF_LEN_DEF
) ();

    logic                ccff_head;
    logic                ccff_tail;
    logic                sc_head;
    logic                sc_tail;
    logic                test_en;
    logic [CCFF_LEN-1:0] cfg_bits;
    logic                cfg_done;

    // Loader side: drives the serial heads and the scan enable.
    modport master (
        output ccff_head, sc_head, test_en,
        input  ccff_tail, sc_tail, cfg_bits, cfg_done
    );

    // Core side: consumes the heads and presents tails, parallel bits and completion.
    modport slave (
        input  ccff_head, sc_head, test_en,
        output ccff_tail, sc_tail, cfg_bits, cfg_done
    );

endinterface

// File: rtl/ccff_shift_reg.sv
// Generic LEN-bit serial-in/parallel-out shift register; q_o[0] holds the newest bit.
module ccff_shift_reg #(
    parameter int LEN = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic           d_i,
    output logic [LEN-1:0] q_o
);

    logic [LEN-1:0] q_q;
    logic [LEN-1:0] q_d;

    // Shift one position towards the tail when enabled, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = {q_q[LEN-2:0], d_i};
        end
    end

    // Chain flops; reset clears the whole chain without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fpga_ccff_chain.sv
// Configuration chain core: bitstream shift register, gated scan chain and load-complete flag.
module fpga_ccff_chain
    import fpga_cfg_pkg::*;
#(
    parameter int CCFF_LEN = CCFF_LEN_DEF,
    parameter int SC_LEN   = SC_LEN_DEF,
    parameter int CNT_W    = cnt_width(CCFF_LEN)
) (
    input  logic               prog_clk,
    input  logic               pReset,
    fpga_ccff_chain_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CCFF_LEN + 1);

    logic [CCFF_LEN-1:0] cfg_q;
    logic [SC_LEN-1:0]   sc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                done_q;
    logic                done_d;
    logic                unused_sc;

    // The configuration chain shifts on every programming edge.
    ccff_shift_reg #(.LEN(CCFF_LEN)) u_cfg_chain (
        .clk_i (prog_clk),
        .rst_i (pReset),
        .en_i  (1'b1),
        .d_i   (bus.ccff_head),
        .q_o   (cfg_q)
    );

    // The scan chain only moves while test mode is enabled.
    ccff_shift_reg #(.LEN(SC_LEN)) u_scan_chain (
        .clk_i (prog_clk),
        .rst_i (pReset),
        .en_i  (bus.test_en),
        .d_i   (bus.sc_head),
        .q_o   (sc_q)
    );

    // Edge counter saturates at CCFF_LEN+1; done follows the saturated state.
    always_comb begin
        cnt_d  = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        done_d = (cnt_d == CNT_MAX);
    end

    // Counter and registered completion flag.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Tails come straight from the last flop of each chain.
    assign bus.ccff_tail = cfg_q[CCFF_LEN-1];
    assign bus.cfg_bits  = cfg_q;
    assign bus.sc_tail   = sc_q[SC_LEN-1];
    assign bus.cfg_done  = done_q;

    // Only the last scan flop leaves the core.
    assign unused_sc = ^sc_q[SC_LEN-2:0];

endmodule

// File: tb/tb_fpga_ccff_chain.sv
// Directed bench for fpga_ccff_chain: a full-length instance and a 16-bit instance.
module tb_fpga_ccff_chain;
    import fpga_cfg_pkg::*;

    localparam int LEN  = CCFF_LEN_DEF;
    localparam int SLEN = 16;
    localparam int SCL  = SC_LEN_DEF;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic rst_s = 1'b0;

    int n_eval = 0;
    int n_fail = 0;

    fpga_ccff_chain_if #(.CCFF_LEN(LEN))  bus_b ();
    fpga_ccff_chain_if #(.CCFF_LEN(SLEN)) bus_s ();

    fpga_ccff_chain #(.CCFF_LEN(LEN), .SC_LEN(SCL)) dut_big (
        .prog_clk (clk),
        .pReset   (rst_b),
        .bus      (bus_b)
    );

    fpga_ccff_chain #(.CCFF_LEN(SLEN), .SC_LEN(SCL)) dut_small (
        .prog_clk (clk),
        .pReset   (rst_s),
        .bus      (bus_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one programming edge and land on the following falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] pat;
        logic [7:0]  replay;
        pat    = 16'hA5C3;
        replay = 8'b1010_0101;

        bus_b.ccff_head = 1'b0;
        bus_b.sc_head   = 1'b0;
        bus_b.test_en   = 1'b0;
        bus_s.ccff_head = 1'b0;
        bus_s.sc_head   = 1'b0;
        bus_s.test_en   = 1'b0;

        // Reset held with the clock running
        #1;
        rst_b = 1'b1;
        rst_s = 1'b1;
        #1;
        chk("rst_tail_t0", {31'd0, bus_b.ccff_tail}, 32'd0);
        chk("rst_done_t0", {31'd0, bus_b.cfg_done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_tail", {31'd0, bus_b.ccff_tail}, 32'd0);
            chk("rst_sctail", {31'd0, bus_b.sc_tail}, 32'd0);
            chk("rst_bits", {31'd0, |bus_b.cfg_bits}, 32'd0);
            chk("rst_done", {31'd0, bus_b.cfg_done}, 32'd0);
        end

        // Pattern load on the 16-bit chain, MSB first
        rst_s = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            bus_s.ccff_head = pat[i];
            tick(1);
        end
        bus_s.ccff_head = 1'b0;
        chk("pat_bits", {16'd0, bus_s.cfg_bits}, 32'h0000A5C3);
        chk("pat_done16", {31'd0, bus_s.cfg_done}, 32'd0);
        for (int j = 7; j >= 0; j--) begin
            chk("pat_replay", {31'd0, bus_s.ccff_tail}, {31'd0, replay[j]});
            tick(1);
            if (j == 7) begin
                chk("pat_done17", {31'd0, bus_s.cfg_done}, 32'd1);
            end
        end
        bus_s.ccff_head = 1'bx;
        tick(1);
        bus_s.ccff_head = 1'b0;
        chk("x_capture", {31'd0, bus_s.cfg_bits[0]}, {31'd0, 1'bx});

        // Scan chain gating
        bus_s.test_en = 1'b0;
        bus_s.sc_head = 1'b1;
        tick(20);
        chk("scan_hold", {31'd0, bus_s.sc_tail}, 32'd0);
        bus_s.test_en = 1'b1;
        tick(SCL - 1);
        chk("scan_pre", {31'd0, bus_s.sc_tail}, 32'd0);
        tick(1);
        chk("scan_tail", {31'd0, bus_s.sc_tail}, 32'd1);

        // Single pulse through the full chain
        rst_b = 1'b0;
        bus_b.ccff_head = 1'b1;
        tick(1);
        bus_b.ccff_head = 1'b0;
        tick(LEN - 2);
        chk("pulse_pre", {31'd0, bus_b.ccff_tail}, 32'd0);
        chk("pulse_done_pre", {31'd0, bus_b.cfg_done}, 32'd0);
        tick(1);
        chk("pulse_tail", {31'd0, bus_b.ccff_tail}, 32'd1);
        chk("pulse_done_len", {31'd0, bus_b.cfg_done}, 32'd0);
        tick(1);
        chk("pulse_post1", {31'd0, bus_b.ccff_tail}, 32'd0);
        chk("pulse_done", {31'd0, bus_b.cfg_done}, 32'd1);
        chk("pulse_cnt", 32'(dut_big.cnt_q), 32'(LEN + 1));
        tick(1);
        chk("pulse_post2", {31'd0, bus_b.ccff_tail}, 32'd0);

        // Asynchronous reset clears done between edges
        rst_b = 1'b1;
        #1;
        chk("arst_done", {31'd0, bus_b.cfg_done}, 32'd0);
        chk("arst_cnt", 32'(dut_big.cnt_q), 32'd0);
        @(negedge clk);
        rst_b = 1'b0;

        // Reset in the middle of a load
        bus_b.ccff_head = 1'b1;
        tick(1);
        bus_b.ccff_head = 1'b0;
        tick(99);
        chk("mid_bit99", {31'd0, bus_b.cfg_bits[99]}, 32'd1);
        chk("mid_cnt100", 32'(dut_big.cnt_q), 32'd100);
        rst_b = 1'b1;
        #1;
        chk("mid_bits", {31'd0, |bus_b.cfg_bits}, 32'd0);
        chk("mid_cnt", 32'(dut_big.cnt_q), 32'd0);
        chk("mid_done", {31'd0, bus_b.cfg_done}, 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        bus_b.ccff_head = 1'b1;
        tick(1);
        bus_b.ccff_head = 1'b0;
        tick(LEN - 2);
        chk("reload_pre", {31'd0, bus_b.ccff_tail}, 32'd0);
        tick(1);
        chk("reload_tail", {31'd0, bus_b.ccff_tail}, 32'd1);

        // Saturation over 2*LEN edges, flushing zeros
        tick(1);
        chk("sat_done_first", {31'd0, bus_b.cfg_done}, 32'd1);
        tick(LEN - 1);
        chk("sat_done", {31'd0, bus_b.cfg_done}, 32'd1);
        chk("sat_cnt", 32'(dut_big.cnt_q), 32'(LEN + 1));
        chk("sat_flush_tail", {31'd0, bus_b.ccff_tail}, 32'd0);
        chk("sat_flush_bits", {31'd0, |bus_b.cfg_bits}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
